// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
// Shared constants, FSM state type and small helpers for the push-button
// interrupt controller (button_intc) and its per-source input stage.
//
// Optional feature macro: INTC_DEBOUNCE_EN (consumed by btn_sync_edge).
// -----------------------------------------------------------------------------
package intc_pkg;

  localparam int              N_SRC      = 4;        // button sources (fixed)
  localparam int              PC_W       = 10;       // CPU program counter width
  localparam logic [PC_W-1:0] VEC_BASE   = 10'h3F0;  // vector of source 0
  localparam int              VEC_STRIDE = 4;        // distance between vectors
  localparam int              DEB_CYCLES = 4;        // debounce stability count

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Fixed priority: the lowest-numbered set bit wins.
  function automatic logic [1:0] prio_enc(input logic [N_SRC-1:0] req);
    prio_enc = 2'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) prio_enc = 2'(i);
    end
  endfunction

  // Handler address; arithmetic wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] vec_addr(input logic [1:0] id);
    vec_addr = VEC_BASE + PC_W'(id) * PC_W'(VEC_STRIDE);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Per-source input stage: two-flop synchroniser, optional debouncer, and a
// press detector that pulses for one cycle on a released->pressed transition.
//
// Ports:
//   clk     in  system clock, rising edge
//   reset   in  synchronous, active-high reset
//   button  in  raw button level, active-low (1 = released)
//   press   out one-cycle press event pulse
//
// Optional feature macro: INTC_DEBOUNCE_EN
//   defined   : level must differ for DEB_CYCLES consecutive cycles to change
//   undefined : synchronised level drives the edge detector directly
// -----------------------------------------------------------------------------
module btn_sync_edge
  import intc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic sync1;
  logic sync2;
  logic level;
  logic prev;

  // NOTE: every flop in the input path resets to 1 (released); otherwise the
  // first cycle after reset would look like a press on every source.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving a
      // true two-stage shift; blocking ones would collapse it to one stage.
      sync1 <= button;
      sync2 <= sync1;
    end
  end

`ifdef INTC_DEBOUNCE_EN
  logic [2:0] deb_cnt;
  logic       stable;

  // Counter tracks consecutive cycles of disagreement; any bounce restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt <= 3'd0;
      stable  <= 1'b1;
    end else if (sync2 != stable) begin
      if (deb_cnt == 3'(DEB_CYCLES - 1)) begin
        stable  <= sync2;
        deb_cnt <= 3'd0;
      end else begin
        deb_cnt <= deb_cnt + 3'd1;
      end
    end else begin
      deb_cnt <= 3'd0;
    end
  end

  assign level = stable;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b1;
    else       prev <= level;
  end

  // Pressed now, released last cycle: a held button gives exactly one pulse.
  assign press = ~level & prev;

endmodule

// File: rtl/button_intc.sv
// -----------------------------------------------------------------------------
// button_intc
// Interrupt controller in front of the CPU: latches active-low button presses,
// arbitrates enabled ones by fixed priority (source 0 highest) and hands one
// request at a time to the CPU with a vector address.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   buttons    in   [N_SRC-1:0] raw push buttons, active-low
//   int_mask   in   [N_SRC-1:0] per-source enable, 1 = enabled
//   ack        in   CPU accepts current request (pulse, honoured in REQ)
//   eoi        in   CPU handler finished (pulse, honoured in SERVICE)
//   irq        out  interrupt request to the CPU
//   vector     out  [PC_W-1:0] handler address for active_id
//   active_id  out  [1:0] source requested or in service
//   pending    out  [N_SRC-1:0] latched press events
//
// Optional feature macro: INTC_DEBOUNCE_EN (debouncer in each input stage).
// -----------------------------------------------------------------------------
module button_intc
  import intc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] buttons,
  input  logic [N_SRC-1:0] int_mask,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [PC_W-1:0]  vector,
  output logic [1:0]       active_id,
  output logic [N_SRC-1:0] pending
);

  logic [N_SRC-1:0] press;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] ack_clr;
  logic [1:0]       next_id;
  state_t           state;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    btn_sync_edge u_btn (
      .clk    (clk),
      .reset  (reset),
      .button (buttons[i]),
      .press  (press[i])
    );
  end

  // Pending bits latch regardless of mask; the mask only gates arbitration.
  assign eligible = pending & int_mask;
  assign next_id  = prio_enc(eligible);

  // NOTE: ack_clr gets a default before the conditional write so the block
  // stays purely combinational instead of inferring a latch.
  always_comb begin
    ack_clr = '0;
    if (state == REQ && ack) ack_clr[active_id] = 1'b1;
  end

  // Set after clear: a press on the acknowledged bit in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~ack_clr) | press;
  end

  // active_id and vector are latched on entry to REQ and held until the next
  // arbitration, so later mask changes cannot withdraw a request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      irq       <= 1'b0;
      active_id <= 2'd0;
      vector    <= VEC_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            active_id <= next_id;
            vector    <= vec_addr(next_id);
            irq       <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // eoi arriving with ack is deliberately not looked at here.
          if (ack) begin
            irq   <= 1'b0;
            state <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) state <= IDLE;
        end
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_intc.sv
// -----------------------------------------------------------------------------
// tb_button_intc
// Self-checking bench for button_intc: directed scenarios with constant
// expectations plus a randomized run compared against a behavioural model
// built from sample histories and a request/service flag pair.
// Build with +define+INTC_DEBOUNCE_EN to exercise the debounced variant.
// -----------------------------------------------------------------------------
module tb_button_intc;

`ifdef INTC_DEBOUNCE_EN
  localparam int DEB = 4;
  localparam int PL  = 5;   // cycles a press is held low
  localparam int LAT = 7;   // edges from first low sample to pending
`else
  localparam int PL  = 1;
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] buttons = 4'hF;
  logic [3:0] int_mask = 4'hF;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;
  logic       irq;
  logic [9:0] vector;
  logic [1:0] active_id;
  logic [3:0] pending;

  int n_checks = 0;
  int n_errors = 0;

  button_intc dut (
    .clk       (clk),
    .reset     (reset),
    .buttons   (buttons),
    .int_mask  (int_mask),
    .ack       (ack),
    .eoi       (eoi),
    .irq       (irq),
    .vector    (vector),
    .active_id (active_id),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_hist[j] = buttons sampled j edges ago; m_st1/m_st2 = clean level after
  // the previous edge and the one before.
  logic [3:0] m_hist [0:7];
  logic [3:0] m_st1 = 4'hF, m_st2 = 4'hF, m_pend = 4'h0;
  logic       m_irq = 1'b0, m_busy = 1'b0;
  logic [1:0] m_id = 2'd0;

  function automatic logic [9:0] exp_vec(input logic [1:0] id);
    exp_vec = 10'((1008 + 4 * int'(id)) % 1024);
  endfunction

  task automatic model_edge();
    logic [3:0] prs, clr, elig, nst;
    if (reset) begin
      for (int j = 0; j < 8; j++) m_hist[j] = 4'hF;
      m_st1 = 4'hF; m_st2 = 4'hF; m_pend = 4'h0;
      m_irq = 1'b0; m_busy = 1'b0; m_id = 2'd0;
    end else begin
      prs = ~m_st1 & m_st2;
      for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = buttons;
`ifdef INTC_DEBOUNCE_EN
      for (int i = 0; i < 4; i++) begin
        logic flip;
        flip = 1'b1;
        for (int j = 2; j <= DEB + 1; j++)
          if (m_hist[j][i] == m_st1[i]) flip = 1'b0;
        nst[i] = flip ? ~m_st1[i] : m_st1[i];
      end
`else
      nst = m_hist[1];
`endif
      m_st2 = m_st1;
      m_st1 = nst;
      clr = 4'h0;
      if (!m_irq && !m_busy) begin
        elig = m_pend & int_mask;
        if (elig != 4'h0) begin
          for (int i = 3; i >= 0; i--) if (elig[i]) m_id = 2'(i);
          m_irq = 1'b1;
        end
      end else if (m_irq) begin
        if (ack) begin
          clr[m_id] = 1'b1;
          m_irq  = 1'b0;
          m_busy = 1'b1;
        end
      end else if (eoi) begin
        m_busy = 1'b0;
      end
      m_pend = (m_pend & ~clr) | prs;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    buttons = 4'hF;
    repeat (n) step();
  endtask

  // Hold 'lo' on the buttons for PL cycles, then release, for LAT edges total.
  task automatic press_wait(input logic [3:0] lo);
    for (int k = 1; k <= LAT; k++) begin
      buttons = (k <= PL) ? lo : 4'hF;
      step();
    end
    buttons = 4'hF;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; buttons = 4'hF; int_mask = 4'hF; ack = 1'b0; eoi = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq cyc %0d got %b exp 0", c, irq); end
      n_checks++;
      if (pending !== 4'h0) begin n_errors++; $display("FAIL reset_pending cyc %0d got %b exp 0000", c, pending); end
      n_checks++;
      if (vector !== 10'h3F0) begin n_errors++; $display("FAIL reset_vector cyc %0d got %h exp 3f0", c, vector); end
      n_checks++;
      if (active_id !== 2'd0) begin n_errors++; $display("FAIL reset_id cyc %0d got %0d exp 0", c, active_id); end
    end
  endtask

  task automatic test_single_press();
    int_mask = 4'hF;
    for (int k = 1; k <= LAT; k++) begin
      buttons = (k <= PL) ? 4'b1110 : 4'hF;
      step();
      if (k == LAT - 1) begin
        n_checks++;
        if (pending !== 4'h0) begin n_errors++; $display("FAIL single_early got %b exp 0000", pending); end
      end
    end
    buttons = 4'hF;
    n_checks++;
    if (pending !== 4'b0001) begin n_errors++; $display("FAIL single_pending got %b exp 0001", pending); end
    step();
    n_checks++;
    if (irq !== 1'b1 || vector !== 10'h3F0 || active_id !== 2'd0) begin
      n_errors++; $display("FAIL single_req got irq=%b vec=%h id=%0d exp 1/3f0/0", irq, vector, active_id);
    end
    pulse_ack();
    n_checks++;
    if (irq !== 1'b0 || pending !== 4'h0) begin
      n_errors++; $display("FAIL single_ack got irq=%b pend=%b exp 0/0000", irq, pending);
    end
    pulse_eoi();
    pulse_ack();  // ack in IDLE must be ignored
    step();
    n_checks++;
    if (irq !== 1'b0 || pending !== 4'h0) begin
      n_errors++; $display("FAIL single_idle got irq=%b pend=%b exp 0/0000", irq, pending);
    end
    settle(12);
  endtask

  task automatic test_priority();
    press_wait(4'b0101);
    n_checks++;
    if (pending !== 4'b1010) begin n_errors++; $display("FAIL prio_pending got %b exp 1010", pending); end
    step();
    n_checks++;
    if (irq !== 1'b1 || active_id !== 2'd1 || vector !== 10'h3F4) begin
      n_errors++; $display("FAIL prio_first got irq=%b id=%0d vec=%h exp 1/1/3f4", irq, active_id, vector);
    end
    pulse_ack();
    n_checks++;
    if (pending !== 4'b1000) begin n_errors++; $display("FAIL prio_clear got %b exp 1000", pending); end
    pulse_eoi();
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL prio_gap got irq=%b exp 0", irq); end
    step();
    n_checks++;
    if (irq !== 1'b1 || active_id !== 2'd3 || vector !== 10'h3FC) begin
      n_errors++; $display("FAIL prio_second got irq=%b id=%0d vec=%h exp 1/3/3fc", irq, active_id, vector);
    end
    pulse_ack();
    pulse_eoi();
    settle(12);
  endtask

  task automatic test_mask();
    int_mask = 4'b1110;
    press_wait(4'b1110);
    repeat (3) step();
    n_checks++;
    if (pending[0] !== 1'b1 || irq !== 1'b0) begin
      n_errors++; $display("FAIL mask_hold got pend0=%b irq=%b exp 1/0", pending[0], irq);
    end
    int_mask = 4'hF;
    step(); step();
    n_checks++;
    if (irq !== 1'b1 || vector !== 10'h3F0 || active_id !== 2'd0) begin
      n_errors++; $display("FAIL mask_enable got irq=%b vec=%h id=%0d exp 1/3f0/0", irq, vector, active_id);
    end
    int_mask = 4'h0;
    step();
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL mask_latched got irq=%b exp 1", irq); end
    int_mask = 4'hF;
    pulse_ack();
    pulse_eoi();
    settle(12);
  endtask

  task automatic test_collision_nesting();
    int_mask = 4'hF;
    press_wait(4'b1011);
    step();
    n_checks++;
    if (irq !== 1'b1 || active_id !== 2'd2) begin
      n_errors++; $display("FAIL coll_req got irq=%b id=%0d exp 1/2", irq, active_id);
    end
    settle(12);
    // Second press whose event lands on the ack edge.
    for (int k = 1; k <= LAT; k++) begin
      buttons = (k <= PL) ? 4'b1011 : 4'hF;
      ack = (k == LAT);
      step();
    end
    ack = 1'b0;
    buttons = 4'hF;
    n_checks++;
    if (pending[2] !== 1'b1 || irq !== 1'b0) begin
      n_errors++; $display("FAIL coll_setwins got pend2=%b irq=%b exp 1/0", pending[2], irq);
    end
    // Source 0 pressed while in SERVICE: no nesting.
    press_wait(4'b1110);
    step(); step();
    n_checks++;
    if (irq !== 1'b0 || pending !== 4'b0101) begin
      n_errors++; $display("FAIL nest_wait got irq=%b pend=%b exp 0/0101", irq, pending);
    end
    pulse_eoi();
    step();
    n_checks++;
    if (irq !== 1'b1 || active_id !== 2'd0 || vector !== 10'h3F0) begin
      n_errors++; $display("FAIL nest_after got irq=%b id=%0d vec=%h exp 1/0/3f0", irq, active_id, vector);
    end
    pulse_ack();
    pulse_eoi();
    step();
    n_checks++;
    if (irq !== 1'b1 || active_id !== 2'd2 || vector !== 10'h3F8) begin
      n_errors++; $display("FAIL nest_src2 got irq=%b id=%0d vec=%h exp 1/2/3f8", irq, active_id, vector);
    end
    pulse_ack();
    pulse_eoi();
    settle(12);
  endtask

  task automatic test_reset_mid();
    press_wait(4'b0111);  // source 3
    step();
    n_checks++;
    if (irq !== 1'b1 || active_id !== 2'd3) begin
      n_errors++; $display("FAIL rstmid_req got irq=%b id=%0d exp 1/3", irq, active_id);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (irq !== 1'b0 || pending !== 4'h0 || vector !== 10'h3F0 || active_id !== 2'd0) begin
      n_errors++; $display("FAIL rstmid_clear got irq=%b pend=%b vec=%h id=%0d exp 0/0000/3f0/0",
                           irq, pending, vector, active_id);
    end
    settle(12);
    n_checks++;
    if (irq !== 1'b0 || pending !== 4'h0) begin
      n_errors++; $display("FAIL rstmid_quiet got irq=%b pend=%b exp 0/0000", irq, pending);
    end
  endtask

`ifdef INTC_DEBOUNCE_EN
  task automatic test_glitch();
    buttons = 4'b1110;
    repeat (3) step();
    settle(14);
    n_checks++;
    if (pending !== 4'h0 || irq !== 1'b0) begin
      n_errors++; $display("FAIL glitch got pend=%b irq=%b exp 0000/0", pending, irq);
    end
  endtask
`endif

  task automatic test_random();
    reset = 1'b1; step(); reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) buttons = 4'($urandom);
      if ($urandom_range(0, 49) == 0) int_mask = 4'($urandom);
      ack   = ($urandom_range(0, 3) == 0);
      eoi   = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 399) == 0);
      step();
      n_checks++;
      if (irq !== m_irq) begin n_errors++; $display("FAIL rand_irq cyc %0d got %b exp %b", c, irq, m_irq); end
      n_checks++;
      if (pending !== m_pend) begin n_errors++; $display("FAIL rand_pending cyc %0d got %b exp %b", c, pending, m_pend); end
      n_checks++;
      if (active_id !== m_id) begin n_errors++; $display("FAIL rand_id cyc %0d got %0d exp %0d", c, active_id, m_id); end
      n_checks++;
      if (vector !== exp_vec(m_id)) begin
        n_errors++; $display("FAIL rand_vector cyc %0d got %h exp %h", c, vector, exp_vec(m_id));
      end
    end
    reset = 1'b0; ack = 1'b0; eoi = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < 8; j++) m_hist[j] = 4'hF;
    test_reset();
    test_single_press();
    test_priority();
    test_mask();
    test_collision_nesting();
    test_reset_mid();
`ifdef INTC_DEBOUNCE_EN
    test_glitch();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
